btn_debounce: RTL and testbench

- Input-conditioning block for the Go Board push-buttons.
- Turns raw, bouncing, asynchronous button pins into synchronized, debounced levels, single-cycle press/release strobes, and per-button toggle states suitable for driving LEDs.
- Sits between the board button pins and any LED or user logic. It replaces direct pin-to-LED wiring wherever clean edges are required.

---
 rtl/btn_debounce_pkg.sv | 32 +++
 rtl/btn_debounce_if.sv | 42 ++++
 rtl/btn_debounce_chan.sv | 198 +++++++++++++++++++
 rtl/btn_debounce.sv | 54 +++++
 tb/tb_btn_debounce.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/btn_debounce_pkg.sv
// -----------------------------------------------------------------------------
// btn_debounce_pkg
//   Shared definitions for the Go Board push-button conditioning block:
//   - btn_state_e   : per-channel debounce FSM states (REL, PCHK, PRS, RCHK)
//   - GO_BOARD_CLK_HZ and the default debounce / auto-repeat periods
//   - ms_to_cycles(): converts a period in milliseconds to clk cycles
// -----------------------------------------------------------------------------
package btn_debounce_pkg;

    // Go Board oscillator frequency.
    localparam int unsigned GO_BOARD_CLK_HZ = 25_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (GO_BOARD_CLK_HZ / 1000) * ms;
    endfunction

    localparam int unsigned DEFAULT_NUM_BTN         = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = ms_to_cycles(10);   // 250_000
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = ms_to_cycles(100);  // 2_500_000

    // REL  : stable released
    // PCHK : candidate press, counting stable-high samples
    // PRS  : stable pressed
    // RCHK : candidate release, counting stable-low samples
    typedef enum logic [1:0] {
        REL  = 2'd0,
        PCHK = 2'd1,
        PRS  = 2'd2,
        RCHK = 2'd3
    } btn_state_e;

endpackage : btn_debounce_pkg

// File: rtl/btn_debounce_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_if
//   Bundles the raw button pins and the conditioned outputs of btn_debounce.
//   Signals (all NUM_BTN wide, one bit per button channel):
//     btn_raw     : raw, bouncing, asynchronous pins (1 = pressed)
//     btn_level   : debounced level
//     btn_press   : one-clock strobe on an accepted press
//     btn_release : one-clock strobe on an accepted release
//     btn_toggle  : flips on every btn_press (LED drive)
//   Modports:
//     master : the board / user side, drives btn_raw and reads the results
//     slave  : the debouncer, reads btn_raw and drives the results
// -----------------------------------------------------------------------------
interface btn_debounce_if
    import btn_debounce_pkg::*;
#(
    parameter int unsigned NUM_BTN = DEFAULT_NUM_BTN
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_toggle;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_toggle
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_toggle
    );

endinterface : btn_debounce_if

// File: rtl/btn_debounce_chan.sv
// -----------------------------------------------------------------------------
// btn_debounce_chan
//   One button channel: 2-flop synchronizer, 4-state debounce FSM with a
//   stability counter, registered level / press / release / toggle outputs.
//
//   Optional feature (macro BTN_DEBOUNCE_AUTO_REPEAT_EN): while the button is
//   held in PRS, a repeat counter re-issues o_btn_press (and flips
//   o_btn_toggle) every REPEAT_CYCLES clocks.
//
//   Ports:
//     clk           : system clock
//     rst_n         : asynchronous active-low reset
//     i_btn_raw     : raw button pin, asynchronous to clk
//     o_btn_level   : debounced level
//     o_btn_press   : one-clock press strobe
//     o_btn_release : one-clock release strobe
//     o_btn_toggle  : flips on every press strobe
// -----------------------------------------------------------------------------
module btn_debounce_chan
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_raw,
    output logic o_btn_level,
    output logic o_btn_press,
    output logic o_btn_release,
    output logic o_btn_toggle
);

    // Stability counter only needs to reach DEBOUNCE_CYCLES-1; it is cleared
    // on every state change, so it can never wrap.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_cfg_check
        $error("btn_debounce_chan: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    // -------------------------------------------------------------------------
    // Synchronizer
    // -------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;

    // NOTE: i_btn_raw is asynchronous; only r_sync2 may feed any logic, giving
    // r_sync1 a full cycle to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM
    // -------------------------------------------------------------------------
    btn_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_toggle;

    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_toggle_nxt;

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    localparam int unsigned REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_cnt_nxt;
`endif

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_toggle_nxt  = r_toggle;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        w_rep_cnt_nxt = r_rep_cnt;
`endif

        case (r_state)
            REL: begin
                if (r_sync2) begin
                    w_state_nxt = PCHK;
                    w_cnt_nxt   = '0;
                end
            end

            PCHK: begin
                if (!r_sync2) begin
                    w_state_nxt = REL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = PRS;
                    w_cnt_nxt    = '0;
                    w_level_nxt  = 1'b1;
                    w_press_nxt  = 1'b1;
                    w_toggle_nxt = ~r_toggle;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                    w_rep_cnt_nxt = '0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            PRS: begin
                if (!r_sync2) begin
                    w_state_nxt = RCHK;
                    w_cnt_nxt   = '0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                end else if (r_rep_cnt == REP_LAST) begin
                    w_rep_cnt_nxt = '0;
                    w_press_nxt   = 1'b1;
                    w_toggle_nxt  = ~r_toggle;
                end else begin
                    w_rep_cnt_nxt = r_rep_cnt + 1'b1;
`endif
                end
            end

            // A bounce back to PRS keeps the repeat phase: the repeat counter
            // is only restarted by a fresh acceptance out of PCHK.
            RCHK: begin
                if (r_sync2) begin
                    w_state_nxt = PRS;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = REL;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = REL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= REL;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_toggle  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_toggle  <= w_toggle_nxt;
        end
    end

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= w_rep_cnt_nxt;
        end
    end
`endif

    assign o_btn_level   = r_level;
    assign o_btn_press   = r_press;
    assign o_btn_release = r_release;
    assign o_btn_toggle  = r_toggle;

endmodule : btn_debounce_chan

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Input conditioning for the Go Board push-buttons. Each of NUM_BTN raw,
//   bouncing, asynchronous pins is synchronized and debounced independently
//   (one btn_debounce_chan per button), producing a clean level, one-clock
//   press / release strobes and a press-toggled LED state.
//
//   Optional feature: define BTN_DEBOUNCE_AUTO_REPEAT_EN to re-issue
//   btn_press every REPEAT_CYCLES clocks while a button stays held.
//
//   Ports:
//     clk     : system clock (25 MHz on the Go Board)
//     rst_n   : asynchronous active-low reset, clears all state
//     btn_bus : btn_debounce_if.slave -- btn_raw in; btn_level, btn_press,
//               btn_release, btn_toggle out
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned NUM_BTN         = DEFAULT_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_debounce_if.slave  btn_bus
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;
    logic [NUM_BTN-1:0] w_toggle;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_btn_raw     (btn_bus.btn_raw[g]),
            .o_btn_level   (w_level[g]),
            .o_btn_press   (w_press[g]),
            .o_btn_release (w_release[g]),
            .o_btn_toggle  (w_toggle[g])
        );
    end

    assign btn_bus.btn_level   = w_level;
    assign btn_bus.btn_press   = w_press;
    assign btn_bus.btn_release = w_release;
    assign btn_bus.btn_toggle  = w_toggle;

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//   Directed scoreboard bench for btn_debounce (NUM_BTN=4, DEBOUNCE_CYCLES=8,
//   REPEAT_CYCLES=20). Stimulus pushes the expected strobe events (cycle,
//   press, release, toggle, level); a monitor pops and compares one entry
//   every cycle the DUT shows a press or release strobe.
//   Define BTN_DEBOUNCE_AUTO_REPEAT_EN to also expect auto-repeat pulses.
//
//   Timing: raw driven at the negedge where cyc==N is first sampled at the
//   posedge that makes cyc==N+1; the strobe is set 10 edges later and is seen
//   at the negedge where cyc==N+11.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int DEB = 8;
    localparam int REP = 20;
    localparam int LAT = DEB + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_debounce_if #(.NUM_BTN(4)) btn_bus ();

    btn_debounce #(
        .NUM_BTN         (4),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_bus (btn_bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] tog;
        logic [3:0] lvl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic push_exp(input int c, input logic [3:0] p, input logic [3:0] r,
                            input logic [3:0] t, input logic [3:0] l);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.tog = t; e.lvl = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest expected event.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && ((btn_bus.btn_press | btn_bus.btn_release) != 4'h0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {btn_bus.btn_press, btn_bus.btn_release}, 8'h00);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_cycle", cyc, mon_e.cyc);
                check("press",        btn_bus.btn_press,   mon_e.press);
                check("release",      btn_bus.btn_release, mon_e.rel);
                check("toggle",       btn_bus.btn_toggle,  mon_e.tog);
                check("level",        btn_bus.btn_level,   mon_e.lvl);
                check("exclusive",    btn_bus.btn_press & btn_bus.btn_release, 4'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        btn_bus.btn_raw = 4'hF;
        rst_n = 1'b0;

        // Reset with all buttons held: everything stays 0.
        wait_cyc(3);
        check("rst_level",   btn_bus.btn_level,   4'h0);
        check("rst_press",   btn_bus.btn_press,   4'h0);
        check("rst_release", btn_bus.btn_release, 4'h0);
        check("rst_toggle",  btn_bus.btn_toggle,  4'h0);

        // Release reset with buttons held: one press strobe on all channels.
        rst_n = 1'b1;
        push_exp(cyc + LAT, 4'hF, 4'h0, 4'hF, 4'hF);
        wait_cyc(20);
        check("held_level", btn_bus.btn_level, 4'hF);
        btn_bus.btn_raw = 4'h0;
        push_exp(cyc + LAT, 4'h0, 4'hF, 4'hF, 4'h0);
        wait_cyc(20);

        // Bounce on btn0: 3-clock segments never accepted, final rise is.
        for (int i = 0; i < 14; i++) begin
            btn_bus.btn_raw[0] = ~btn_bus.btn_raw[0];
            wait_cyc(3);
        end
        btn_bus.btn_raw[0] = 1'b1;
        push_exp(cyc + LAT, 4'h1, 4'h0, 4'hE, 4'h1);
        wait_cyc(20);
        btn_bus.btn_raw[0] = 1'b0;
        push_exp(cyc + LAT, 4'h0, 4'h1, 4'hE, 4'h0);
        wait_cyc(20);

        // 7-clock glitch on btn2: no strobe, no state change.
        btn_bus.btn_raw[2] = 1'b1;
        wait_cyc(7);
        btn_bus.btn_raw[2] = 1'b0;
        wait_cyc(20);
        check("glitch_level",  btn_bus.btn_level,  4'h0);
        check("glitch_toggle", btn_bus.btn_toggle, 4'hE);

        // Reset mid-check on btn3 (async), then re-debounce while held.
        btn_bus.btn_raw[3] = 1'b1;
        wait_cyc(6);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_toggle", btn_bus.btn_toggle, 4'h0);
        check("async_rst_level",  btn_bus.btn_level,  4'h0);
        wait_cyc(3);
        rst_n = 1'b1;
        push_exp(cyc + LAT, 4'h8, 4'h0, 4'h8, 4'h8);
        wait_cyc(20);
        btn_bus.btn_raw[3] = 1'b0;
        push_exp(cyc + LAT, 4'h0, 4'h8, 4'h8, 4'h0);
        wait_cyc(20);

        // Two press/release cycles on btn1: toggle[1] 0 -> 1 -> 0.
        btn_bus.btn_raw[1] = 1'b1;
        push_exp(cyc + LAT, 4'h2, 4'h0, 4'hA, 4'h2);
        wait_cyc(20);
        btn_bus.btn_raw[1] = 1'b0;
        push_exp(cyc + LAT, 4'h0, 4'h2, 4'hA, 4'h0);
        wait_cyc(20);
        btn_bus.btn_raw[1] = 1'b1;
        push_exp(cyc + LAT, 4'h2, 4'h0, 4'h8, 4'h2);
        wait_cyc(20);
        btn_bus.btn_raw[1] = 1'b0;
        push_exp(cyc + LAT, 4'h0, 4'h2, 4'h8, 4'h0);
        wait_cyc(20);

        // Simultaneous: press btn0+btn3 while releasing btn1 on one edge.
        btn_bus.btn_raw = 4'h2;
        push_exp(cyc + LAT, 4'h2, 4'h0, 4'hA, 4'h2);
        wait_cyc(20);
        btn_bus.btn_raw = 4'h9;
        push_exp(cyc + LAT, 4'h9, 4'h2, 4'h3, 4'h9);
        wait_cyc(20);
        btn_bus.btn_raw = 4'h0;
        push_exp(cyc + LAT, 4'h0, 4'h9, 4'h3, 4'h0);
        wait_cyc(20);

        // Long hold on btn0: 70 clocks after acceptance, then release.
        btn_bus.btn_raw[0] = 1'b1;
        a = cyc + LAT;
        push_exp(a, 4'h1, 4'h0, 4'h2, 4'h1);
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        push_exp(a + REP,     4'h1, 4'h0, 4'h3, 4'h1);
        push_exp(a + 2 * REP, 4'h1, 4'h0, 4'h2, 4'h1);
        push_exp(a + 3 * REP, 4'h1, 4'h0, 4'h3, 4'h1);
`endif
        wait_cyc(LAT + 70);
        btn_bus.btn_raw[0] = 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        push_exp(cyc + LAT, 4'h0, 4'h1, 4'h3, 4'h0);
`else
        push_exp(cyc + LAT, 4'h0, 4'h1, 4'h2, 4'h0);
`endif
        wait_cyc(40);

        check("pending_events", exp_q.size(), 0);
        check("final_level",    btn_bus.btn_level, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_btn_debounce
